// File: rtl/mips_defs_pkg.sv
// Shared definitions for the writeback-side blocks.
//  REG_ZERO           hard-wired zero register index; never written
//  wba_state_e        write-port arbiter states
package mips_defs;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WBA_IDLE  = 2'd0,
        WBA_WAIT  = 2'd1,
        WBA_STEAL = 2'd2
    } wba_state_e;

endpackage

// File: rtl/wb_port_arbiter_hold_buffer.sv
// One-entry hold buffer for a long-latency result waiting for the write port.
//  clk, rst           clock, asynchronous active-high reset
//  load               capture load_addr/load_data and mark the entry valid
//  clear              empty the entry (address and data return to zero)
//  valid, addr, data  current contents
module wb_hold_buffer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;

    // Entry storage; load and clear are never requested together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            addr_r  <= load_addr;
            data_r  <= load_data;
        end else if (clear) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
        end else begin
            valid_r <= valid_r;
            addr_r  <= addr_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign addr  = addr_r;
    assign data  = data_r;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the MEM/WB pipeline write and one
// long-latency unit (LU). The pipeline has priority; the LU result waits in a
// one-entry buffer and, after STARVE_LIMIT consecutive lost cycles, a one-cycle
// pipeline stall is requested so the buffer can take the port.
//  pipe_*             MEM/WB destination, write enable, data
//  lu_valid/lu_ready  LU result handshake (lu_ready registered, high only in IDLE)
//  lu_dest_addr/wdata LU result destination and data
//  stall_req          freeze the pipeline this cycle
//  lu_pending(_addr)  buffer occupied / its destination, for hazard detection
//  rf_we/waddr/wdata  register-file write port
module wb_port_arbiter
    import mips_defs::*;
#(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pipe_dest_addr,
    input  logic              pipe_write_or_not,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_dest_addr,
    input  logic [DATA_W-1:0] lu_wdata,
    output logic              lu_ready,
    output logic              stall_req,
    output logic              lu_pending,
    output logic [ADDR_W-1:0] lu_pending_addr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(STARVE_LIMIT - 1);

    wba_state_e        state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              lu_ready_r;
    logic              buf_load_s, buf_clear_s;
    logic              buf_valid_s;
    logic [ADDR_W-1:0] buf_addr_s;
    logic [DATA_W-1:0] buf_data_s;
    logic              grant_buf_s;
    logic              g_we_s;
    logic [ADDR_W-1:0] g_addr_s;
    logic [DATA_W-1:0] g_data_s;

    wb_hold_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load_s),
        .clear     (buf_clear_s),
        .load_addr (lu_dest_addr),
        .load_data (lu_wdata),
        .valid     (buf_valid_s),
        .addr      (buf_addr_s),
        .data      (buf_data_s)
    );

    // State, starvation counter and the registered accept flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= WBA_IDLE;
            cnt_r      <= '0;
            lu_ready_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            lu_ready_r <= (state_next_s == WBA_IDLE);
        end
    end

    // Next state, counter and buffer control.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        buf_load_s   = 1'b0;
        buf_clear_s  = 1'b0;
        case (state_r)
            WBA_IDLE: begin
                // A result for r0 is accepted but simply not stored.
                if (lu_valid && lu_ready_r && (lu_dest_addr != ZERO_ADDR)) begin
                    state_next_s = WBA_WAIT;
                    cnt_next_s   = '0;
                    buf_load_s   = 1'b1;
                end else begin
                    state_next_s = WBA_IDLE;
                end
            end
            WBA_WAIT: begin
                if (!pipe_write_or_not) begin
                    state_next_s = WBA_IDLE;
                    buf_clear_s  = 1'b1;
                end else if (pipe_dest_addr == buf_addr_s) begin
                    // Younger pipeline write to the same register makes the LU result dead.
                    state_next_s = WBA_IDLE;
                    buf_clear_s  = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = WBA_STEAL;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            WBA_STEAL: begin
                state_next_s = WBA_IDLE;
                buf_clear_s  = 1'b1;
            end
            default: begin
                state_next_s = WBA_IDLE;
                buf_clear_s  = 1'b1;
            end
        endcase
    end

    // Write-port mux; reset forces the port quiet without waiting for an edge.
    always_comb begin
        grant_buf_s = (state_r == WBA_STEAL) ||
                      ((state_r == WBA_WAIT) && !pipe_write_or_not);
        if (grant_buf_s) begin
            g_we_s   = buf_valid_s;
            g_addr_s = buf_addr_s;
            g_data_s = buf_data_s;
        end else begin
            g_we_s   = pipe_write_or_not;
            g_addr_s = pipe_dest_addr;
            g_data_s = pipe_wdata;
        end
        if (rst) begin
            rf_we    = 1'b0;
            rf_waddr = '0;
            rf_wdata = '0;
        end else begin
            rf_we    = g_we_s && (g_addr_s != ZERO_ADDR);
            rf_waddr = g_addr_s;
            rf_wdata = g_data_s;
        end
    end

    assign lu_ready        = lu_ready_r;
    assign stall_req       = (state_r == WBA_STEAL);
    assign lu_pending      = (state_r != WBA_IDLE);
    assign lu_pending_addr = buf_addr_s;

endmodule
